// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse train generator: FSM state encoding and
// the width of the phase down-counter.
package pulse_pkg;

    // Width of the phase timer; HIGH_CYC and LOW_CYC must fit in it.
    localparam int PHASE_W = 8;

    // Generator state: waiting for a trigger, driving a high phase, or
    // holding the gap between two pulses.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pulse_state_t;

endpackage : pulse_pkg

// File: rtl/phase_timer.sv
// Loadable down-counter that times one HIGH or LOW phase of the pulse train.
// A phase loaded with N lasts exactly N cycles; expire is high in the last
// cycle of the phase so the owner can load the next phase in time.
module phase_timer
    import pulse_pkg::*;
(
    input  logic               clk,
    input  logic               reset_p,
    input  logic               load,
    input  logic [PHASE_W-1:0] load_val,
    output logic [PHASE_W-1:0] value,
    output logic               expire
);

    // Load a new phase length, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - PHASE_W'(1);
        end
    end

    assign expire = (value == PHASE_W'(1));

endmodule : phase_timer

// File: rtl/pulse_train_gen.sv
// Pulse train generator: on an accepted trig it emits `count` pulses of
// HIGH_CYC high cycles separated by LOW_CYC low cycles, with registered
// rise/fall/busy/done status.
// Optional feature: define PULSE_TRAIN_RETRIGGER_EN to let a trig with a
// nonzero count restart the train while it is still running.
module pulse_train_gen
    import pulse_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int HIGH_CYC = 3,
    parameter int LOW_CYC  = 2
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             trig,
    input  logic [CNT_W-1:0] count,
    output logic             pulse_out,
    output logic             rise,
    output logic             fall,
    output logic             busy,
    output logic             done
);

    localparam logic [PHASE_W-1:0] HIGH_LOAD = PHASE_W'(HIGH_CYC);
    localparam logic [PHASE_W-1:0] LOW_LOAD  = PHASE_W'(LOW_CYC);

    pulse_state_t       state;
    logic [CNT_W-1:0]   remaining;
    logic               start;
    logic               last_pulse;
    logic               timer_load;
    logic [PHASE_W-1:0] timer_val;
    logic [PHASE_W-1:0] phase_value;
    logic               phase_expire;
    logic               unused_phase_bits;

    // The phase value is exported by the timer for observation only.
    assign unused_phase_bits = ^phase_value;

`ifdef PULSE_TRAIN_RETRIGGER_EN
    // Any trig with a nonzero count (re)starts the train, even mid-train.
    assign start = trig && (count != '0);
`else
    // Only an idle generator accepts a trig; a zero count is never a start.
    assign start = trig && (count != '0) && (state == ST_IDLE);
`endif

    // The pulse now ending is the final one when the counter holds one.
    assign last_pulse = (remaining == CNT_W'(1));

    // Decide when the phase timer must be loaded and with which length.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = HIGH_LOAD;
        if (start) begin
            timer_load = 1'b1;
            timer_val  = HIGH_LOAD;
        end else if ((state == ST_HIGH) && phase_expire && !last_pulse) begin
            timer_load = 1'b1;
            timer_val  = LOW_LOAD;
        end else if ((state == ST_LOW) && phase_expire) begin
            timer_load = 1'b1;
            timer_val  = HIGH_LOAD;
        end
    end

    phase_timer u_phase_timer (
        .clk      (clk),
        .reset_p  (reset_p),
        .load     (timer_load),
        .load_val (timer_val),
        .value    (phase_value),
        .expire   (phase_expire)
    );

    // Pulse FSM with the remaining-pulse counter and all registered outputs.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state     <= ST_IDLE;
            remaining <= '0;
            pulse_out <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_HIGH;
                        remaining <= count;
                        pulse_out <= 1'b1;
                        rise      <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (start) begin
                        remaining <= count;
                    end else if (phase_expire) begin
                        remaining <= remaining - CNT_W'(1);
                        pulse_out <= 1'b0;
                        fall      <= 1'b1;
                        if (last_pulse) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    if (start || phase_expire) begin
                        state     <= ST_HIGH;
                        pulse_out <= 1'b1;
                        rise      <= 1'b1;
                        if (start) begin
                            remaining <= count;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    remaining <= '0;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule : pulse_train_gen
